// File: rtl/paralleltoserial_pkg.sv
// Constants shared by the serializer and its matching deserializer:
// idle/sync character, preamble length and the FSM state encoding.
package paralleltoserial_pkg;

  localparam logic [7:0] COMMA_DEFAULT      = 8'hBC;
  localparam int         SYNC_COUNT_DEFAULT = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/paralleltoserial.sv
// Byte-to-bit serializer. It sends a COMMA preamble after reset, then sends bytes
// MSB first, back-to-back. COMMA fills every slot that has no valid byte.
module paralleltoserial
  import paralleltoserial_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEFAULT,
  parameter int          SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_ready,
  output logic       data_out,
  output logic       active_out
);

  localparam logic [2:0] LAST_SYNC = 3'(SYNC_COUNT - 1);

  state_t      state;
  state_t      next_state;
  logic [2:0]  bit_cnt;
  logic [2:0]  sync_cnt;
  logic [6:0]  shift;
  logic        load;
  logic [7:0]  load_byte;

  always_ff @(posedge clk_8f) begin
    if (!reset_L) state <= SYNC;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_byte  = COMMA;
    load       = (bit_cnt == 3'd7);
    data_ready = load && (state == ACTIVE);
    case (state)
      SYNC: begin
        if (load && (sync_cnt == LAST_SYNC)) next_state = ACTIVE;
      end
      ACTIVE: begin
        if (valid_in) load_byte = data_in;
      end
    endcase
  end

  // The MSB goes straight to data_out at the load edge. Only the remaining seven bits are kept to shift out.
  always_ff @(posedge clk_8f) begin
    if (!reset_L) begin
      bit_cnt    <= 3'd7;
      sync_cnt   <= 3'd0;
      shift      <= 7'd0;
      data_out   <= 1'b0;
      active_out <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt + 3'd1;
      active_out <= (next_state == ACTIVE);
      if (load) begin
        data_out <= load_byte[7];
        shift    <= load_byte[6:0];
        if (state == SYNC) sync_cnt <= sync_cnt + 3'd1;
      end else begin
        data_out <= shift[6];
        shift    <= {shift[5:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_paralleltoserial.sv
// Self-checking bench for paralleltoserial. A slot-level reference model predicts
// every serial bit, active_out and data_ready. Inputs are randomized outside load edges.
module tb_paralleltoserial;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         SC    = 4;

  logic       clk_8f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_ready;
  logic       data_out;
  logic       active_out;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         t        = -1;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] rx       = 8'h00;
  logic       exp_out;
  logic       exp_act;
  logic       exp_rdy;

  always #5 clk_8f = ~clk_8f;

  paralleltoserial dut (
    .clk_8f     (clk_8f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_ready (data_ready),
    .data_out   (data_out),
    .active_out (active_out)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("[TB] FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
  endtask

  // One clock. t counts edges since reset was released, and edge 0 is the first load.
  task automatic step(input logic rst, input logic v, input logic [7:0] d);
    reset_L  = rst;
    valid_in = v;
    data_in  = d;
    @(posedge clk_8f);
    #1;
    if (!rst) begin
      t       = -1;
      exp_out = 1'b0;
      exp_act = 1'b0;
      exp_rdy = 1'b0;
    end else begin
      t++;
      if (t % 8 == 0) cur_byte = ((t / 8 >= SC) && v) ? d : COMMA;
      exp_out = cur_byte[7 - (t % 8)];
      exp_act = (t >= 8 * (SC - 1));
      exp_rdy = ((t + 1) % 8 == 0) && ((t + 1) / 8 >= SC);
    end
    rx = {rx[6:0], data_out};
    check("data_out",   {7'd0, data_out},   {7'd0, exp_out});
    check("active_out", {7'd0, active_out}, {7'd0, exp_act});
    check("data_ready", {7'd0, data_ready}, {7'd0, exp_rdy});
  endtask

  // One byte slot. (v,d) is applied only at the load edge. Other cycles get random noise.
  task automatic slot(input logic v, input logic [7:0] d);
    for (int k = 0; k < 8; k++) begin
      if ((t + 1) % 8 == 0) step(1'b1, v, d);
      else                  step(1'b1, 1'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;

    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("reset_data_out", {7'd0, data_out}, 8'd0);

    // Valid 0xAA is held through the preamble. It must be ignored until the preamble completes.
    for (int i = 0; i < SC; i++) begin
      slot(1'b1, 8'hAA);
      check("sync_comma", rx, COMMA);
    end
    check("active_after_sync", {7'd0, active_out}, 8'd1);
    slot(1'b1, 8'hAA);
    check("first_data_aa", rx, 8'hAA);

    slot(1'b1, 8'hFF); check("byte_ff", rx, 8'hFF);
    slot(1'b1, 8'hEE); check("byte_ee", rx, 8'hEE);
    slot(1'b1, 8'hDD); check("byte_dd", rx, 8'hDD);

    for (int i = 0; i < 2; i++) begin
      slot(1'b1, 8'h55); check("alt_data", rx, 8'h55);
      slot(1'b0, 8'h55); check("alt_idle", rx, COMMA);
    end

    // Abort a byte partway through. A full preamble must follow release.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h12);
    step(1'b0, 1'b1, 8'h12);
    check("midreset_data_out", {7'd0, data_out}, 8'd0);
    check("midreset_active",   {7'd0, active_out}, 8'd0);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < SC; i++) begin
      slot(1'b0, 8'h00);
      check("resync_comma", rx, COMMA);
    end
    slot(1'b1, 8'h3C); check("post_resync_data", rx, 8'h3C);

    for (int i = 0; i < 24; i++) begin
      slot(1'($urandom), 8'($urandom));
      check("random_byte", rx, cur_byte);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/paralleltoserial.md
PARALLELTOSERIAL -- requirements
Module: paralleltoserial

Interface
REQ-001 The block SHALL have parameter COMMA, default 8'hBC, meaning the idle/sync character sent when no valid data is available.
REQ-002 The block SHALL have parameter SYNC_COUNT, default 4, meaning the number of COMMA bytes sent after reset before data is accepted.
REQ-003 The block SHALL have port clk_8f  input  1  bit clock; the only clock, one serial bit per rising edge.
REQ-004 The block SHALL have port reset_L  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port data_in  input  8  parallel byte to serialize.
REQ-006 The block SHALL have port valid_in  input  1  data_in holds a valid byte.
REQ-007 The block SHALL have port data_ready  output  1  byte slot open; upstream data_in/valid_in are sampled at the clk_8f edge ending this cycle.
REQ-008 The block SHALL have port data_out  output  1  serial bit stream, MSB first.
REQ-009 The block SHALL have port active_out  output  1  high once sync preamble is complete (state ACTIVE).

Function
REQ-010 The block SHALL keep a 3-bit bit counter bit_cnt that increments every clk_8f edge out of reset and wraps 7->0.
REQ-011 A "load edge" SHALL be any edge where bit_cnt==7; at it the next byte is captured into the shift register.
REQ-012 In the 8 cycles following a load edge, data_out SHALL equal byte[7], byte[6], ... byte[0], one bit per cycle, registered.
REQ-013 The FSM SHALL have states SYNC and ACTIVE; reset enters SYNC.
REQ-014 In SYNC, every load SHALL capture COMMA regardless of valid_in; a 3-bit sync counter SHALL increment per load.
REQ-015 The load that captures the SYNC_COUNT-th COMMA SHALL move the FSM to ACTIVE at that same edge.
REQ-016 In ACTIVE, a load SHALL capture data_in if valid_in==1, else COMMA.
REQ-017 data_ready SHALL be high exactly when bit_cnt==7 and state==ACTIVE; low otherwise, including throughout SYNC.
REQ-018 valid_in/data_in values outside data_ready cycles SHALL be ignored.
REQ-019 active_out SHALL equal (state==ACTIVE), registered.
REQ-020 Bytes SHALL be sent back-to-back with no gap bits; a serial byte boundary occurs every 8 clk_8f cycles.
REQ-021 A valid byte whose value equals COMMA SHALL be sent unchanged; the downstream receiver then treats it as idle (documented limitation).

Reset
REQ-022 While reset_L==0 at an edge: data_out=0, data_ready=0, active_out=0, bit_cnt=7, sync counter=0, shift register=0, state=SYNC.
REQ-023 The first edge with reset_L==1 SHALL be a load edge capturing COMMA; the first COMMA bit appears in the following cycle.
REQ-024 Reset asserted mid-byte SHALL abort the byte at the next edge and restart the full SYNC preamble on release.

Structure
REQ-025 COMMA default, SYNC_COUNT default and FSM state encodings SHALL live in a shared constants include used with serialtopar.
REQ-026 No sub-module; shift register, bit counter, sync counter and FSM in one module (about 150-250 lines RTL).
REQ-027 A conductual model and a Yosys-synthesized estructural version SHALL both exist and be compared by a checker on identical stimulus.

Verification
REQ-028 Reset low 2 cycles then high, valid_in=0 -> 4 x 0xBC on data_out (10111100 each), active_out rises at the 4th load, 0xBC continues.
REQ-029 After sync, present 0xFF,0xEE,0xDD with valid_in=1 on successive data_ready cycles -> serial 11111111 11101110 11011101, no gaps.
REQ-030 valid_in=1, data_in=0xAA held during SYNC -> ignored; first 0xAA appears only after 4 commas, in the slot after the first data_ready.
REQ-031 Alternate valid_in 1/0 per slot with 0x55 -> stream 01010101, 10111100, 01010101, ...
REQ-032 Assert reset_L=0 at bit 3 of a data byte -> data_out=0 next edge; on release, 4 fresh commas precede any data.
REQ-033 Loop data_out into serialtopar (clk_f=clk_8f/8, aligned) -> serialtopar valid_out rises after sync and data_out_c reproduces 0xFF,0xEE,0xDD; conductual and estructural outputs match every cycle.
